// File: rtl/player_motion_ctrl.sv
// Per-frame player movement controller: bounds-checks a one-step move, probes the
// collision RAM at two leading-edge points, then commits or rejects. Define PLAYER_NOCLIP_EN to ignore collisions.
module player_motion_ctrl #(
    parameter int MAP_W   = 320,
    parameter int MAP_H   = 240,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int STEP    = 1,
    parameter int START_X = 152,
    parameter int START_Y = 112
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [7:0]  keycode,
    output logic [18:0] col_addr,
    input  logic [3:0]  col_data,
    output logic [8:0]  pos_x,
    output logic [7:0]  pos_y,
    output logic [1:0]  facing,
    output logic        moving,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_CHECK0, S_CHECK1} state_t;
    typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_LEFT = 2'd1, DIR_DOWN = 2'd2, DIR_RIGHT = 2'd3} dir_t;

    localparam logic [9:0] STEP_X = 10'(STEP);
    localparam logic [8:0] STEP_Y = 9'(STEP);
    localparam logic [9:0] X_MAX  = 10'(MAP_W - SPR_W);
    localparam logic [8:0] Y_MAX  = 9'(MAP_H - SPR_H);

    state_t      r_state;
    dir_t        r_dir;
    dir_t        r_facing;
    logic [8:0]  r_pos_x;
    logic [7:0]  r_pos_y;
    logic [8:0]  r_cand_x;
    logic [7:0]  r_cand_y;
    logic [18:0] r_col_addr;
    logic        r_moving;
    logic        r_busy;
    logic        r_blk0;

    logic        w_key_valid;
    dir_t        w_key_dir;
    logic [9:0]  w_cand_x;
    logic [8:0]  w_cand_y;
    logic        w_in_bounds;
    logic [8:0]  w_right;
    logic [7:0]  w_bottom;
    logic [8:0]  w_p0_x, w_p1_x;
    logic [7:0]  w_p0_y, w_p1_y;
    logic        w_blk;

    function automatic logic [18:0] addr_of(input logic [8:0] x, input logic [7:0] y);
        return 19'(y) * 19'(MAP_W) + 19'(x);
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_key_valid = 1'b1;
        w_key_dir   = DIR_DOWN;
        case (keycode)
            8'h1A:   w_key_dir = DIR_UP;
            8'h04:   w_key_dir = DIR_LEFT;
            8'h16:   w_key_dir = DIR_DOWN;
            8'h07:   w_key_dir = DIR_RIGHT;
            default: w_key_valid = 1'b0;
        endcase
    end

    // One bit wider so a step below zero wraps to a huge value and fails the max check.
    always_comb begin
        w_cand_x = {1'b0, r_pos_x};
        w_cand_y = {1'b0, r_pos_y};
        case (w_key_dir)
            DIR_UP:   w_cand_y = {1'b0, r_pos_y} - STEP_Y;
            DIR_LEFT: w_cand_x = {1'b0, r_pos_x} - STEP_X;
            DIR_DOWN: w_cand_y = {1'b0, r_pos_y} + STEP_Y;
            default:  w_cand_x = {1'b0, r_pos_x} + STEP_X;
        endcase
    end

    assign w_in_bounds = (w_cand_x <= X_MAX) && (w_cand_y <= Y_MAX);

    assign w_right  = r_cand_x + 9'(SPR_W - 1);
    assign w_bottom = r_cand_y + 8'(SPR_H - 1);

    always_comb begin
        w_p0_x = r_cand_x;
        w_p0_y = r_cand_y;
        w_p1_x = w_right;
        w_p1_y = r_cand_y;
        case (r_dir)
            DIR_UP: begin
                w_p0_x = r_cand_x; w_p0_y = r_cand_y;
                w_p1_x = w_right;  w_p1_y = r_cand_y;
            end
            DIR_DOWN: begin
                w_p0_x = r_cand_x; w_p0_y = w_bottom;
                w_p1_x = w_right;  w_p1_y = w_bottom;
            end
            DIR_LEFT: begin
                w_p0_x = r_cand_x; w_p0_y = r_cand_y;
                w_p1_x = r_cand_x; w_p1_y = w_bottom;
            end
            default: begin
                w_p0_x = w_right;  w_p0_y = r_cand_y;
                w_p1_x = w_right;  w_p1_y = w_bottom;
            end
        endcase
    end

`ifdef PLAYER_NOCLIP_EN
    // Probe data is still consumed so timing is unchanged; it just never blocks.
    assign w_blk = (|col_data) & 1'b0;
`else
    assign w_blk = |col_data;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_dir      <= DIR_DOWN;
            r_facing   <= DIR_DOWN;
            r_pos_x    <= 9'(START_X);
            r_pos_y    <= 8'(START_Y);
            r_cand_x   <= 9'(START_X);
            r_cand_y   <= 8'(START_Y);
            r_col_addr <= '0;
            r_moving   <= 1'b0;
            r_busy     <= 1'b0;
            r_blk0     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        if (!w_key_valid) begin
                            r_moving <= 1'b0;
                        end else begin
                            r_facing <= w_key_dir;
                            r_dir    <= w_key_dir;
                            r_cand_x <= w_cand_x[8:0];
                            r_cand_y <= w_cand_y[7:0];
                            if (w_in_bounds) begin
                                r_state <= S_ISSUE0;
                                r_busy  <= 1'b1;
                            end else begin
                                r_moving <= 1'b0;
                            end
                        end
                    end
                end
                S_ISSUE0: begin
                    r_col_addr <= addr_of(w_p0_x, w_p0_y);
                    r_state    <= S_ISSUE1;
                end
                S_ISSUE1: begin
                    r_col_addr <= addr_of(w_p1_x, w_p1_y);
                    r_state    <= S_CHECK0;
                end
                S_CHECK0: begin
                    r_blk0  <= w_blk;
                    r_state <= S_CHECK1;
                end
                S_CHECK1: begin
                    if (!r_blk0 && !w_blk) begin
                        r_pos_x  <= r_cand_x;
                        r_pos_y  <= r_cand_y;
                        r_moving <= 1'b1;
                    end else begin
                        r_moving <= 1'b0;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign col_addr = r_col_addr;
    assign pos_x    = r_pos_x;
    assign pos_y    = r_pos_y;
    assign facing   = r_facing;
    assign moving   = r_moving;
    assign busy     = r_busy;

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Per-frame player movement controller for the overworld. On each frame tick it reads the held direction key and computes a candidate sprite position. It probes the collision memory at two points on the sprite's leading edge, then commits or rejects the move. It sits directly upstream of the collision RAM (drives its read address, consumes its 1-cycle-latency `data_Out`). Its position and facing outputs feed the character/map sprite renderers.

## Interface
- `MAP_W`, 320, map width in pixels; collision RAM row stride
- `MAP_H`, 240, map height in pixels
- `SPR_W`, 16, player sprite width
- `SPR_H`, 16, player sprite height
- `STEP`, 1, pixels moved per committed move
- `START_X`, 152, reset x (top-left)
- `START_Y`, 112, reset y (top-left)

Clocking and reset: single clock `Clk`; `Reset` is synchronous and active-high.

- `Clk`  in  1  system clock
- `Reset`  in  1  synchronous active-high reset
- `frame_tick`  in  1  one-cycle pulse per frame
- `keycode`  in  8  USB HID keycode
  - 0x1A W = up
  - 0x04 A = left
  - 0x16 S = down
  - 0x07 D = right
  - anything else = none
- `col_addr`  out  19  collision RAM read address (registered)
- `col_data`  in  4  collision RAM read data; nonzero = blocked
- `pos_x`  out  9  sprite top-left x
- `pos_y`  out  8  sprite top-left y
- `facing`  out  2  direction code: 0 up, 1 left, 2 down, 3 right
- `moving`  out  1  last accepted tick committed a move
- `busy`  out  1  probe sequence in progress

## Operation
- Reset values:
  - `pos_x`=START_X, `pos_y`=START_Y
  - `facing`=2, `moving`=0, `busy`=0, `col_addr`=0
  - state IDLE
- States: IDLE, ISSUE0, ISSUE1, CHECK0, CHECK1.

IDLE, on `frame_tick`:
- Non-direction keycode: `moving`<=0, stay IDLE.
- Direction keycode:
  - latch direction; `facing`<=dir
  - cand = pos ± STEP on that axis, computed one bit wider to detect underflow
- Bounds check: cand must satisfy 0≤cx≤MAP_W−SPR_W and 0≤cy≤MAP_H−SPR_H.
  - Out of bounds: `moving`<=0, stay IDLE, no probes issued.
  - In bounds: go ISSUE0.

Probe points (x,y), with R=cx+SPR_W−1 and B=cy+SPR_H−1:
- up: (cx,cy), (R,cy)
- down: (cx,B), (R,B)
- left: (cx,cy), (cx,B)
- right: (R,cy), (R,B)

Probe sequence:
- ISSUE0: `col_addr`<=p0.y*MAP_W+p0.x; go ISSUE1.
- ISSUE1: `col_addr`<=p1 address; go CHECK0.
- CHECK0: latch blk0 = (`col_data`≠0); go CHECK1.
- CHECK1: blk1 = (`col_data`≠0).
  - If !blk0 && !blk1: pos<=cand, `moving`<=1.
  - Else: `moving`<=0, pos unchanged.
  - Go IDLE.

Other rules:
- Address arithmetic is 19-bit unsigned; max 76799; never wraps, because bounds are checked first.
- `busy`=1 in every state except IDLE.
- `frame_tick` while busy is ignored: not queued, not counted.
- `keycode` is sampled only at the IDLE tick; changes during the probe sequence have no effect.
- Reset in any state: immediate return to reset values; no commit.

## Timing
- Tick sampled at edge 0 → `col_addr`=p0 after edge 1, p1 after edge 2.
- `col_data` for p0 is sampled at edge 3 and for p1 at edge 4.
- `pos_x`/`pos_y`/`moving` update after edge 4.
- Probe latency 4 cycles; always well under one frame.
- `facing` updates after edge 0, even for rejected moves.

## Configuration
- `PLAYER_NOCLIP_EN` defined:
  - probes are still issued with identical timing
  - blk0/blk1 are forced to 0, so every in-bounds move commits
  - bounds checks remain active
- Undefined: collision results gate commits as above.

## Test plan
- Reset high 2 cycles → pos=(152,112), facing=2, moving=0, busy=0, col_addr=0.
- keycode 0x07, tick, col_data=0 → col_addr 36008 then 40808; pos_x=153 four cycles after tick; moving=1; busy high for cycles 1–4.
- Same stimulus, col_data=1 at p1 only → pos stays (152,112), facing=3, moving=0.
- pos_x=0, keycode 0x04, tick → busy never asserts, no col_addr change, facing=1, moving=0, pos unchanged.
- Second tick at cycle 2 of a probe → ignored, exactly one move. Reset asserted in CHECK0 → pos=(152,112), state IDLE.
- Build with `PLAYER_NOCLIP_EN`, keycode 0x1A, col_data=0xF → pos_y=111 after 4 cycles, moving=1.
